mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-ported 16-bit byte-addressed memory between an instruction-fetch
//  port (read-only) and a data port (read/write), e.g. a unified instruction/data memory.
//  Sequences each access over WAIT_CYCLES so one transaction is outstanding at a time.
//  Never drives a read and a write to the memory in the same cycle.
//  Issues exactly one write clock edge per store.
// PARAMETERS
//  ADDR_WIDTH   16  byte-address width of all ports; memory ignores addr[0]
//  WAIT_CYCLES  2   cycles mem_enable is held per access; legal range >=1
// PORTS
//  clk         in   1    system clock, rising edge
//  rst         in   1    asynchronous, active-high reset
//  i_req       in   1    fetch request; held with i_addr stable until i_ack
//  i_addr      in   AW   fetch byte address
//  i_ack       out  1    one-cycle pulse: fetch complete, i_rdata valid
//  i_rdata     out  16   registered fetch data; holds until next i_ack
//  i_err       out  1    misaligned-fetch flag, pulses with i_ack (macro only)
//  d_req       in   1    data request; held with d_wr/d_addr/d_wdata stable until d_ack
//  d_wr        in   1    1=store, 0=load
//  d_addr      in   AW   data byte address
//  d_wdata     in   16   store data
//  d_ack       out  1    one-cycle pulse: load/store complete
//  d_rdata     out  16   registered load data; holds until next load d_ack
//  d_err       out  1    misaligned-data flag, pulses with d_ack (macro only)
//  mem_enable  out  1    to memory enable
//  mem_wr      out  1    to memory wr
//  mem_addr    out  AW   to memory addr
//  mem_wdata   out  16   to memory data_in
//  mem_rdata   in   16   from memory data_out (combinational read)
//  busy        out  1    state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=INSTR, all outputs 0 (incl. rdata regs). Mid-transaction
//    reset drops the access: no ack; mem_wr low before the next edge, so no store lands.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE.
//    IDLE: no req: stay. Otherwise pick a port, latch its addr/wr/wdata/id, load cnt=WAIT_CYCLES-1.
//    Both req: grant port != last_grant (data wins first after reset). Update last_grant on grant.
//  - ACCESS: mem_enable=1, mem_addr/mem_wdata = latched values.
//    Load: mem_wr=0 throughout; mem_rdata captured into the port's rdata reg on the edge
//    leaving the final ACCESS cycle.
//    Store: mem_wr=1 only in the final ACCESS cycle (cnt==0), giving one write edge.
//    Not final cycle: cnt decrements. Final cycle: go to DONE.
//  - DONE: granted port's ack=1 for this cycle only; no arbitration; go to IDLE. The requester
//    drops req on the edge after ack, so IDLE never re-serves it.
//  - Latency: req high in IDLE cycle T -> ACCESS T+1..T+WAIT_CYCLES -> ack at T+WAIT_CYCLES+1.
//    Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
//  - Outside ACCESS: mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0.
//  - Req or input changes while not granted or not in IDLE are ignored until the next IDLE.
//  - cnt width = $clog2(WAIT_CYCLES+1). WAIT_CYCLES=1 gives a single ACCESS cycle.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: a granted request with addr[0]=1 goes IDLE->DONE directly.
//    No memory cycle (mem_enable stays 0). ack and err pulse together; load rdata=16'h0000.
//    Store is discarded. Ack arrives at T+1.
//  Not defined: i_err/d_err tied 0; addr passed unchanged (memory drops bit 0).
// TESTING
//  1 assert rst, toggle all inputs -> all outputs 0, mem_enable never high; busy=0
//  2 WAIT=2: data store 0x0010<-0xBEEF at T -> mem_wr high only at T+2, d_ack at T+3;
//    then fetch 0x0010 -> i_rdata=0xBEEF with i_ack
//  3 i_req and d_req both high -> data served first, then fetch; repeat both -> fetch first
//  4 preloaded memory, fetches 0x0000 then 0x0002 back-to-back -> correct words,
//    i_ack 4 cycles apart (WAIT=2)
//  5 rst pulsed during ACCESS of store 0x0020<-0x1234 -> no d_ack, mem[0x0020] unchanged,
//    FSM IDLE
//  6 d_addr=0x0011 load: macro on -> d_ack+d_err at T+1, d_rdata=0, no mem_enable;
//    macro off -> normal access of word 0x0010

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the data port and the memory-side
// bus of mem_arbiter.
//   slave  : arbiter side (takes requests and mem_rdata, drives acks/rdata/err and memory controls)
//   master : environment side (requesters plus the memory model)
// Fetch:  i_req, i_addr -> i_ack, i_rdata, i_err
// Data:   d_req, d_wr, d_addr, d_wdata -> d_ack, d_rdata, d_err
// Memory: mem_enable, mem_wr, mem_addr, mem_wdata -> mem_rdata (combinational read)
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic [15:0]           i_rdata;
    logic                  i_err;

    logic                  d_req;
    logic                  d_wr;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [15:0]           d_wdata;
    logic                  d_ack;
    logic [15:0]           d_rdata;
    logic                  d_err;

    logic                  mem_enable;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_wdata;
    logic [15:0]           mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_enable, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_enable, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported 16-bit memory between a read-only
// fetch port and a read/write data port. One access is outstanding at a time;
// each access holds mem_enable for WAIT_CYCLES cycles and a store raises
// mem_wr only in the last of them, so exactly one write edge lands.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_if.slave (fetch port, data port, memory bus)
//   busy - high whenever the FSM is not IDLE
// Optional feature: define MEM_ALIGN_CHECK_EN to reject odd addresses
// (no memory cycle, ack+err together, loads return 0). Without it the
// err outputs stay 0 and odd addresses go to memory unchanged.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus,
    output logic            busy
);
    localparam int             CW       = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic           PORT_I   = 1'b0;
    localparam logic           PORT_D   = 1'b1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic                  id;     // PORT_I / PORT_D
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [15:0]           wdata;
    } req_t;

    state_t        state, state_nx;
    req_t          pick, lat;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          any_req;
    logic          skip;       // granted request bypasses the memory cycle
    logic [15:0]   i_rdata_q, d_rdata_q;

    // Arbitration: with both ports requesting, the one not served last wins.
    always_comb begin
        pick       = '0;
        any_req    = bus.i_req | bus.d_req;
        pick.id    = (bus.d_req & (~bus.i_req | (last_grant == PORT_I))) ? PORT_D : PORT_I;
        pick.wr    = (pick.id == PORT_D) & bus.d_wr;
        pick.addr  = (pick.id == PORT_D) ? bus.d_addr : bus.i_addr;
        pick.wdata = (pick.id == PORT_D) ? bus.d_wdata : 16'h0000;
`ifdef MEM_ALIGN_CHECK_EN
        skip       = pick.addr[0];
`else
        skip       = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = skip ? DONE : ACCESS;
            ACCESS:  if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, wait counter, grant history and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat        <= '0;
            cnt        <= '0;
            last_grant <= PORT_I;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else if (state == IDLE && any_req) begin
            lat        <= pick;
            cnt        <= CNT_LAST;
            last_grant <= pick.id;
            // Rejected load returns zero alongside its ack.
            if (skip && !pick.wr) begin
                if (pick.id == PORT_D) d_rdata_q <= '0;
                else                   i_rdata_q <= '0;
            end
        end else if (state == ACCESS) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (!lat.wr) begin
                if (lat.id == PORT_D) d_rdata_q <= bus.mem_rdata;
                else                  i_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Memory controls are forced to zero outside ACCESS; because they are
    // decoded from state, an async reset drops mem_wr before the next edge.
    always_comb begin
        bus.mem_enable = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.i_ack      = 1'b0;
        bus.d_ack      = 1'b0;
        bus.i_err      = 1'b0;
        bus.d_err      = 1'b0;
        busy           = (state != IDLE);
        case (state)
            ACCESS: begin
                bus.mem_enable = 1'b1;
                bus.mem_wr     = lat.wr & (cnt == '0);
                bus.mem_addr   = lat.addr;
                bus.mem_wdata  = lat.wdata;
            end
            DONE: begin
                bus.i_ack = (lat.id == PORT_I);
                bus.d_ack = (lat.id == PORT_D);
`ifdef MEM_ALIGN_CHECK_EN
                bus.i_err = (lat.id == PORT_I) & lat.addr[0];
                bus.d_err = (lat.id == PORT_D) & lat.addr[0];
`endif
            end
            default: ;
        endcase
    end

    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic preload = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    mem_arbiter_if #(.ADDR_WIDTH(16)) bus ();

    mem_arbiter #(.ADDR_WIDTH(16), .WAIT_CYCLES(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pre(input int i);
        return 16'(i * 313) ^ 16'hA5C3;
    endfunction

    // Word memory with combinational read; bit 0 of the byte address is ignored.
    logic [15:0] mem [0:32767];
    assign bus.mem_rdata = mem[bus.mem_addr[15:1]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32768; i++) mem[i] <= pre(i);
        end else if (bus.mem_enable && bus.mem_wr) begin
            mem[bus.mem_addr[15:1]] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    // Issue one request (caller is at a negedge) and follow it to its ack.
    task automatic do_txn(input bit is_d, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] rdata,
                          output int lat, output int ack_c, output int wr_cnt,
                          output int wr_off, output int en_cnt, output logic err);
        int start;
        bit got;
        start = cyc; got = 1'b0; rdata = '0; lat = -1; ack_c = -1;
        wr_cnt = 0; wr_off = -1; en_cnt = 0; err = 1'b0;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_wr = wr; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (bus.mem_wr) begin
                wr_cnt++;
                if (wr_off < 0) wr_off = cyc - start;
            end
            if (bus.mem_enable) en_cnt++;
            if (is_d ? bus.d_ack : bus.i_ack) begin
                got   = 1'b1;
                lat   = cyc - start;
                ack_c = cyc;
                rdata = is_d ? bus.d_rdata : bus.i_rdata;
                err   = is_d ? bus.d_err : bus.i_err;
            end
        end
        if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
        chk(is_d ? "d_ack_seen" : "i_ack_seen", 32'(got), 32'd1);
    endtask

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        tbl [6];
    logic [15:0] r1, r2;
    int          l1, l2, a1, a2, wc1, wc2, wo1, wo2, en1, en2, nack;
    logic        e1, e2;

    // random-phase reference state
    logic [15:0] shadow [0:63];
    bit          pend [2];
    bit          rwr [2];
    logic [15:0] raddr [2];
    logic [15:0] rwd [2];
    bit          act, lg, ei, ed;
    int          srv, ack_c, free_c, wrc, c;

    initial begin
        idle_inputs();
        tbl[0] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000,  W + 1};
        tbl[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF,  W + 1};
        tbl[2] = '{1'b1, 1'b1, 16'h0012, 16'h5A5A, 16'h0000,  W + 1};
        tbl[3] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'h5A5A,  W + 1};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, pre(0),    W + 1};
        tbl[5] = '{1'b1, 1'b0, 16'h0040, 16'h0000, pre(16'h20), W + 1};

        // reset holds every output at zero whatever the inputs do
        @(negedge clk);
        preload = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.i_req = 1'($urandom); bus.i_addr = 16'($urandom);
            bus.d_req = 1'($urandom); bus.d_wr = 1'($urandom);
            bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
            @(negedge clk);
            chk("rst_flags", 32'({bus.i_ack, bus.d_ack, bus.i_err, bus.d_err,
                                  bus.mem_enable, bus.mem_wr, busy}), 32'd0);
            chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 32'd0);
            chk("rst_membus", {bus.mem_addr, bus.mem_wdata}, 32'd0);
        end
        idle_inputs();
        rst = 1'b0;

        // single transactions, each started from IDLE
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            do_txn(tbl[i].is_d, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                   r1, l1, a1, wc1, wo1, en1, e1);
            chk($sformatf("vec%0d_lat", i), 32'(l1), 32'(tbl[i].exp_lat));
            chk($sformatf("vec%0d_wrcnt", i), 32'(wc1), tbl[i].wr ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d_encnt", i), 32'(en1), 32'(W));
            chk($sformatf("vec%0d_err", i), 32'(e1), 32'd0);
            if (tbl[i].wr) chk($sformatf("vec%0d_wroff", i), 32'(wo1), 32'(W));
            else           chk($sformatf("vec%0d_rdata", i), 32'(r1), 32'(tbl[i].exp_rdata));
        end

        // back-to-back fetches
        @(negedge clk);
        do_txn(1'b0, 1'b0, 16'h0000, 16'h0, r1, l1, a1, wc1, wo1, en1, e1);
        do_txn(1'b0, 1'b0, 16'h0002, 16'h0, r2, l2, a2, wc2, wo2, en2, e2);
        chk("b2b_word0", 32'(r1), 32'(pre(0)));
        chk("b2b_word1", 32'(r2), 32'(pre(1)));
        chk("b2b_gap", 32'(a2 - a1), 32'(W + 2));

        // odd data address
        @(negedge clk);
        do_txn(1'b1, 1'b0, 16'h0011, 16'h0, r1, l1, a1, wc1, wo1, en1, e1);
`ifdef MEM_ALIGN_CHECK_EN
        chk("odd_lat", 32'(l1), 32'd1);
        chk("odd_err", 32'(e1), 32'd1);
        chk("odd_rdata", 32'(r1), 32'd0);
        chk("odd_encnt", 32'(en1), 32'd0);
`else
        chk("odd_lat", 32'(l1), 32'(W + 1));
        chk("odd_err", 32'(e1), 32'd0);
        chk("odd_rdata", 32'(r1), 32'hBEEF);
        chk("odd_encnt", 32'(en1), 32'(W));
`endif

        // reset during the ACCESS phase of a store
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0020; bus.d_wdata = 16'h1234;
        @(negedge clk);
        chk("rst5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst5_idle", 32'({busy, bus.mem_enable, bus.mem_wr}), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        nack = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.d_ack || bus.i_ack) nack++;
        end
        chk("rst5_no_ack", 32'(nack), 32'd0);
        chk("rst5_mem", 32'(mem[16]), 32'(pre(16)));
        chk("rst5_busy", 32'(busy), 32'd0);

        // arbitration: fresh reset favours data, then alternate
        @(negedge clk);
        fork
            do_txn(1'b0, 1'b0, 16'h0004, 16'h0, r1, l1, a1, wc1, wo1, en1, e1);
            do_txn(1'b1, 1'b0, 16'h0006, 16'h0, r2, l2, a2, wc2, wo2, en2, e2);
        join
        chk("arb1_data_first", 32'(a2 < a1), 32'd1);
        chk("arb1_gap", 32'(a1 - a2), 32'(W + 2));
        chk("arb1_i_data", 32'(r1), 32'(pre(2)));
        chk("arb1_d_data", 32'(r2), 32'(pre(3)));
        @(negedge clk);
        do_txn(1'b1, 1'b1, 16'h0030, 16'h7777, r2, l2, a2, wc2, wo2, en2, e2);
        @(negedge clk);
        fork
            do_txn(1'b0, 1'b0, 16'h0030, 16'h0, r1, l1, a1, wc1, wo1, en1, e1);
            do_txn(1'b1, 1'b0, 16'h0004, 16'h0, r2, l2, a2, wc2, wo2, en2, e2);
        join
        chk("arb2_fetch_first", 32'(a1 < a2), 32'd1);
        chk("arb2_i_data", 32'(r1), 32'h7777);
        chk("arb2_d_data", 32'(r2), 32'(pre(2)));

        // randomized traffic against a transaction-level model
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) shadow[i] = mem[i];
        pend[0] = 1'b0; pend[1] = 1'b0;
        act = 1'b0; lg = 1'b0; srv = 0; ack_c = -1; wrc = 0;
        free_c = cyc;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            c  = cyc;
            ei = act && srv == 0 && c == ack_c;
            ed = act && srv == 1 && c == ack_c;
            chk("rnd_i_ack", 32'(bus.i_ack), 32'(ei));
            chk("rnd_d_ack", 32'(bus.d_ack), 32'(ed));
            if (act && bus.mem_wr) wrc++;
            if (act && c == ack_c) begin
                if (srv == 1 && rwr[1]) begin
                    shadow[raddr[1][6:1]] = rwd[1];
                    chk("rnd_store_mem", 32'(mem[raddr[1][15:1]]), 32'(rwd[1]));
                    chk("rnd_store_wrcnt", 32'(wrc), 32'd1);
                end else begin
                    chk("rnd_load", 32'(srv == 1 ? bus.d_rdata : bus.i_rdata),
                        32'(shadow[raddr[srv][6:1]]));
                    chk("rnd_load_wrcnt", 32'(wrc), 32'd0);
                end
                pend[srv] = 1'b0;
                if (srv == 1) bus.d_req = 1'b0; else bus.i_req = 1'b0;
                act = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 3) == 0) begin
                    pend[p]  = 1'b1;
                    raddr[p] = {9'h0, 6'($urandom_range(0, 63)), 1'b0};
                    rwr[p]   = (p == 1) ? 1'($urandom) : 1'b0;
                    rwd[p]   = 16'($urandom);
                    if (p == 1) begin
                        bus.d_req = 1'b1; bus.d_wr = rwr[1];
                        bus.d_addr = raddr[1]; bus.d_wdata = rwd[1];
                    end else begin
                        bus.i_req = 1'b1; bus.i_addr = raddr[0];
                    end
                end
            end
            // an idle arbiter serves the lone requester, or the one not served last
            if (!act && c >= free_c && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) srv = lg ? 0 : 1;
                else                    srv = pend[1] ? 1 : 0;
                lg     = (srv == 1);
                act    = 1'b1;
                ack_c  = c + W + 1;
                free_c = ack_c + 1;
                wrc    = 0;
            end
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
